// File: rtl/decode_cycle_pkg.sv
// Shared decode encodings for decode_cycle: opcodes, funct3 codes, ALU control,
// immediate and result selects, the ID/EX register layout and the immediate generator.
package decode_cycle_pkg;

  localparam int REG_AW = 5;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'b000,
    IMM_I    = 3'b001,
    IMM_S    = 3'b010,
    IMM_B    = 3'b011,
    IMM_J    = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    result_src_e result_src;
    alu_ctrl_e   alu_ctrl;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        valid;
    logic        illegal;
  } idex_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_src_e src);
    logic [31:0] imm;
    case (src)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_cycle_register_file.sv
// register_file: NUM_REGS x XLEN, two combinational reads, one write, synchronous clear.
// x0 is hard-wired to zero. Optional macro RF_WRITE_BYPASS_EN forwards a same-cycle write to the reads.
module register_file
  import decode_cycle_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic            wr_en;

  assign wr_en = we && (wa != {REG_AW{1'b0}});

  // next-state of the array: at most one entry replaced, x0 never written
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wa] = wd;
    end else begin
      regs_d = regs_q;
    end
  end

  // storage; reset wins over any write presented in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // read ports
  always_comb begin
    rd1 = (ra1 == {REG_AW{1'b0}}) ? {XLEN{1'b0}} : regs_q[ra1];
    rd2 = (ra2 == {REG_AW{1'b0}}) ? {XLEN{1'b0}} : regs_q[ra2];
`ifdef RF_WRITE_BYPASS_EN
    if (wr_en && (wa == ra1)) begin
      rd1 = wd;
    end else begin
      rd1 = rd1;
    end
    if (wr_en && (wa == ra2)) begin
      rd2 = wd;
    end else begin
      rd2 = rd2;
    end
`endif
  end

endmodule

// File: rtl/decode_cycle.sv
// decode_cycle: RV32 decode stage (lw/sw/R/I-ALU/beq/jal) with register file and ID/EX register.
// Optional macro RF_WRITE_BYPASS_EN enables write-to-read forwarding inside the register file.
module decode_cycle
  import decode_cycle_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            ValidE,
  output logic            IllegalE
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_b5;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  ctrl_t           dec_ctrl;
  imm_src_e        imm_src;
  logic            dec_illegal;
  alu_ctrl_e       alu_arith;
  idex_t           idex_d;
  idex_t           idex_q;

  assign opcode    = InstrD[6:0];
  assign funct3    = InstrD[14:12];
  assign funct7_b5 = InstrD[30];

  register_file #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_register_file (
    .clk (clk),
    .rst (rst),
    .ra1 (InstrD[19:15]),
    .ra2 (InstrD[24:20]),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (RegWriteW),
    .wa  (RdW),
    .wd  (ResultW)
  );

  // ALU op for R-type / I-ALU; subtract only for R-type with funct7[5] set
  always_comb begin
    alu_arith = ALU_ADD;
    case (funct3)
      F3_ADD:  alu_arith = ((opcode == OP_RTYP) && funct7_b5) ? ALU_SUB : ALU_ADD;
      F3_SLT:  alu_arith = ALU_SLT;
      F3_OR:   alu_arith = ALU_OR;
      F3_AND:  alu_arith = ALU_AND;
      default: alu_arith = ALU_ADD;
    endcase
  end

  // main control decode
  always_comb begin
    dec_ctrl    = '0;
    imm_src     = IMM_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      OP_LW: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.result_src = RES_MEM;
        dec_ctrl.alu_ctrl   = ALU_ADD;
        imm_src             = IMM_I;
      end
      OP_SW: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_ctrl  = ALU_ADD;
        imm_src            = IMM_S;
      end
      OP_RTYP: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_ctrl  = alu_arith;
      end
      OP_IALU: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_ctrl  = alu_arith;
        imm_src            = IMM_I;
      end
      OP_BEQ: begin
        dec_ctrl.branch   = 1'b1;
        dec_ctrl.alu_ctrl = ALU_SUB;
        imm_src           = IMM_B;
      end
      OP_JAL: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.jump       = 1'b1;
        dec_ctrl.result_src = RES_PC4;
        dec_ctrl.alu_ctrl   = ALU_ADD;
        imm_src             = IMM_J;
      end
      default: begin
        dec_ctrl    = '0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // ID/EX next state: a flush inserts an all-zero bubble
  always_comb begin
    idex_d = '0;
    if (FlushE) begin
      idex_d = '0;
    end else begin
      idex_d.ctrl     = dec_ctrl;
      idex_d.rd1      = rf_rd1;
      idex_d.rd2      = rf_rd2;
      idex_d.imm      = imm_gen(InstrD, imm_src);
      idex_d.pc       = PCD;
      idex_d.pc_plus4 = PCPlus4D;
      idex_d.rs1      = InstrD[19:15];
      idex_d.rs2      = InstrD[24:20];
      idex_d.rd       = InstrD[11:7];
      idex_d.valid    = 1'b1;
      idex_d.illegal  = dec_illegal;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign RegWriteE   = idex_q.ctrl.reg_write;
  assign MemWriteE   = idex_q.ctrl.mem_write;
  assign JumpE       = idex_q.ctrl.jump;
  assign BranchE     = idex_q.ctrl.branch;
  assign ALUSrcE     = idex_q.ctrl.alu_src;
  assign ResultSrcE  = idex_q.ctrl.result_src;
  assign ALUControlE = idex_q.ctrl.alu_ctrl;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign ValidE      = idex_q.valid;
  assign IllegalE    = idex_q.illegal;

endmodule
